// File: rtl/bitwise_result_stage.sv
// Result stage for the bitwise slice array: two-entry skid buffer with stored zero/parity flags and an accumulator of retired results.
// Optional BITWISE_RESULT_STAGE_PERF_EN adds saturating retired/stall counters.
module bitwise_result_stage #(
   parameter int WIDTH = 8,
   parameter int TAGW  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_q,
   input  logic [1:0]       s_op,
   input  logic [TAGW-1:0]  s_tag,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       m_op,
   output logic [TAGW-1:0]  m_tag,
   output logic             m_zero,
   output logic             m_parity,
`ifdef BITWISE_RESULT_STAGE_PERF_EN
   output logic [WIDTH-1:0] acc_q,
   output logic [15:0]      perf_retired,
   output logic [15:0]      perf_stall
`else
   output logic [WIDTH-1:0] acc_q
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [1:0]       op;
      logic [TAGW-1:0]  tag;
      logic             zero;
      logic             parity;
   } entry_t;

   function automatic logic calc_zero(input logic [WIDTH-1:0] v);
      return (v == '0);
   endfunction

   function automatic logic calc_parity(input logic [WIDTH-1:0] v);
      return ^v;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t           state_q, state_d;
   entry_t           head_q, head_d, sec_q, sec_d, new_e;
   logic             s_ready_q;
   logic [WIDTH-1:0] acc_d;
   logic             push, pop;

   assign push = s_valid & s_ready_q;
   assign pop  = m_valid & m_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      sec_d   = sec_q;
      acc_d   = acc_q;
      // Flags are taken from s_q here and stored, keeping s_q off the m_* flag paths.
      new_e   = '{data: s_q, op: s_op, tag: s_tag, zero: calc_zero(s_q), parity: calc_parity(s_q)};
      if (pop) acc_d = head_q.data;
      case (state_q)
         EMPTY: if (push) begin
            head_d  = new_e;
            state_d = ONE;
         end
         ONE: begin
            if (push && pop) begin
               head_d = new_e;
            end else if (push) begin
               sec_d   = new_e;
               state_d = FULL;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: if (pop) begin
            head_d  = sec_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         s_ready_q <= 1'b1;
         head_q    <= '0;
         sec_q     <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d != FULL);
         head_q    <= head_d;
         sec_q     <= sec_d;
         acc_q     <= acc_d;
      end
   end

`ifdef BITWISE_RESULT_STAGE_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_retired <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop) perf_retired <= sat_inc(perf_retired);
         if (s_valid && !s_ready_q) perf_stall <= sat_inc(perf_stall);
      end
   end
`endif

   assign s_ready  = s_ready_q;
   assign m_valid  = (state_q != EMPTY);
   assign m_data   = head_q.data;
   assign m_op     = head_q.op;
   assign m_tag    = head_q.tag;
   assign m_zero   = head_q.zero;
   assign m_parity = head_q.parity;

endmodule

// File: tb/tb_bitwise_result_stage.sv
// Directed bench for bitwise_result_stage: reset, latency, backpressure, streaming, push+pop, mid-run reset.
module tb_bitwise_result_stage;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s_valid, s_ready, m_valid, m_ready, m_zero, m_parity;
   logic [7:0] s_q, m_data, acc_q;
   logic [1:0] s_op, m_op;
   logic [2:0] s_tag, m_tag;
`ifdef BITWISE_RESULT_STAGE_PERF_EN
   logic [15:0] perf_retired, perf_stall;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bitwise_result_stage #(.WIDTH(8), .TAGW(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_valid(s_valid), .s_ready(s_ready), .s_q(s_q), .s_op(s_op), .s_tag(s_tag),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_op(m_op), .m_tag(m_tag),
      .m_zero(m_zero), .m_parity(m_parity),
`ifdef BITWISE_RESULT_STAGE_PERF_EN
      .acc_q(acc_q), .perf_retired(perf_retired), .perf_stall(perf_stall)
`else
      .acc_q(acc_q)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; s_valid = 1'b0; s_q = '0; s_op = '0; s_tag = '0; m_ready = 1'b0;
      step(); step();
      check("rst_s_ready", 32'(s_ready), 32'd1);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data",  32'(m_data),  32'd0);
      check("rst_acc",     32'(acc_q),   32'd0);
      check("rst_flags",   32'({m_zero, m_parity}), 32'd0);
      rst_n = 1'b1;

      // single push, 1-cycle latency, then retire into acc
      s_valid = 1'b1; s_q = 8'hA5; s_op = 2'b01; s_tag = 3'd3; m_ready = 1'b1;
      step();
      s_valid = 1'b0;
      check("t1_m_valid",  32'(m_valid),  32'd1);
      check("t1_m_data",   32'(m_data),   32'hA5);
      check("t1_m_zero",   32'(m_zero),   32'd0);
      check("t1_m_parity", 32'(m_parity), 32'd0);
      check("t1_m_tag",    32'(m_tag),    32'd3);
      check("t1_m_op",     32'(m_op),     32'd1);
      step();
      check("t1_acc",      32'(acc_q),    32'hA5);
      check("t1_m_valid0", 32'(m_valid),  32'd0);

      // fill to FULL under backpressure, ignored third push
      m_ready = 1'b0; s_valid = 1'b1; s_q = 8'h00; s_op = 2'b10; s_tag = 3'd1;
      step();
      check("t2_head0",   32'(m_data),  32'h00);
      check("t2_zero",    32'(m_zero),  32'd1);
      check("t2_ready1",  32'(s_ready), 32'd1);
      s_q = 8'h01; s_tag = 3'd2;
      step();
      check("t2_ready_full", 32'(s_ready), 32'd0);
      check("t2_head_full",  32'(m_data),  32'h00);
      s_q = 8'hFF; s_tag = 3'd7;
      step();
      check("t2_still_full", 32'(s_ready), 32'd0);
      check("t2_head_hold",  32'(m_data),  32'h00);
      check("t2_tag_hold",   32'(m_tag),   32'd1);
      s_valid = 1'b0; m_ready = 1'b1;
      step();
      check("t2_pop1_data", 32'(m_data),  32'h01);
      check("t2_pop1_zero", 32'(m_zero),  32'd0);
      check("t2_pop1_acc",  32'(acc_q),   32'h00);
      check("t2_pop1_rdy",  32'(s_ready), 32'd1);
      step();
      check("t2_pop2_valid", 32'(m_valid), 32'd0);
      check("t2_pop2_acc",   32'(acc_q),   32'h01);

      // streaming 0..15 at full throughput
      m_ready = 1'b1; s_valid = 1'b1; s_op = 2'b11; s_tag = 3'd5;
      for (int i = 0; i < 16; i++) begin
         s_q = 8'(i);
         step();
         check("t3_data",  32'(m_data),  32'(i));
         check("t3_valid", 32'(m_valid), 32'd1);
         check("t3_ready", 32'(s_ready), 32'd1);
         if (i > 0) check("t3_acc", 32'(acc_q), 32'(i - 1));
      end
      s_valid = 1'b0;
      step();
      check("t3_final_acc", 32'(acc_q),   32'd15);
      check("t3_drained",   32'(m_valid), 32'd0);

      // ONE with head 3C, simultaneous push C3 and pop
      m_ready = 1'b0; s_valid = 1'b1; s_q = 8'h3C; s_tag = 3'd4;
      step();
      check("t4_head", 32'(m_data), 32'h3C);
      s_q = 8'hC3; s_tag = 3'd6; m_ready = 1'b1;
      step();
      check("t4_data",   32'(m_data),   32'hC3);
      check("t4_parity", 32'(m_parity), 32'd0);
      check("t4_acc",    32'(acc_q),    32'h3C);
      check("t4_tag",    32'(m_tag),    32'd6);
      s_q = 8'h55; m_ready = 1'b0;
      step();
      s_valid = 1'b0;
      check("t4_was_one", 32'(s_ready), 32'd0);
      check("t4_keep",    32'(m_data),  32'hC3);
      m_ready = 1'b1;
      step(); step();
      check("t4_drain_acc", 32'(acc_q),   32'h55);
      check("t4_drained",   32'(m_valid), 32'd0);

      // FULL with 11/22, then reset mid-operation with a push attempt
      m_ready = 1'b0; s_valid = 1'b1; s_q = 8'h11;
      step();
      s_q = 8'h22;
      step();
      check("t5_full", 32'(s_ready), 32'd0);
      rst_n = 1'b0; m_ready = 1'b1;
      step();
      rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
      check("t5_rst_valid", 32'(m_valid), 32'd0);
      check("t5_rst_ready", 32'(s_ready), 32'd1);
      check("t5_rst_acc",   32'(acc_q),   32'd0);
      check("t5_rst_data",  32'(m_data),  32'd0);
      step();
      check("t5_post_empty", 32'(m_valid), 32'd0);
      s_valid = 1'b1; s_q = 8'h7F; s_tag = 3'd2;
      step();
      s_valid = 1'b0;
      check("t5_data",   32'(m_data),   32'h7F);
      check("t5_parity", 32'(m_parity), 32'd1);
      m_ready = 1'b1;
      step();
      check("t5_acc", 32'(acc_q), 32'h7F);

`ifdef BITWISE_RESULT_STAGE_PERF_EN
      rst_n = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
      step();
      rst_n = 1'b1;
      check("p_rst_stall", 32'(perf_stall),   32'd0);
      s_valid = 1'b1; s_q = 8'h0A;
      for (int i = 0; i < 5; i++) step();
      s_valid = 1'b0;
      check("p_stall",   32'(perf_stall),   32'd3);
      check("p_retired", 32'(perf_retired), 32'd0);
      m_ready = 1'b1;
      step(); step();
      check("p_retired2", 32'(perf_retired), 32'd2);
      check("p_stall2",   32'(perf_stall),   32'd3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bitwise_result_stage.md
Name: bitwise_result_stage

Overview:
- Downstream stage of the bitwise logic slice array. Captures the WIDTH-bit result vector (one q per slice) together with its op code and destination tag.
- Computes zero and parity flags and buffers up to two results in a skid buffer with valid/ready handshakes on both sides.
- Holds the last retired result in an accumulator register. The accumulator feeds back as the A operand of the slice array.

Parameters:
- WIDTH, 8, number of bitwise slices / result bits
- TAGW, 3, destination register tag width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- s_valid  input  1  upstream result valid
- s_ready  output  1  stage can accept a result this cycle
- s_q  input  WIDTH  result bits from slice array (bit i = slice i q)
- s_op  input  2  {op1,op0} used for this result (00 pass B, 01 XOR, 10 AND, 11 OR)
- s_tag  input  TAGW  destination register tag
- m_valid  output  1  head entry valid
- m_ready  input  1  downstream consumes head entry
- m_data  output  WIDTH  head result
- m_op  output  2  head op code
- m_tag  output  TAGW  head destination tag
- m_zero  output  1  head result == 0
- m_parity  output  1  XOR-reduction of head result
- acc_q  output  WIDTH  last retired result (A-operand feedback)

Behaviour:
- Handshakes: push = s_valid & s_ready; pop = m_valid & m_ready. Both are evaluated on the same edge.
- Entries: each holds {data, op, tag, zero, parity}. Flags are computed from s_q at push time and stored, so there is no combinational path from s_q to m_zero/m_parity.
- State machine on occupancy, three states:
  - EMPTY: push → ONE.
  - ONE: push & !pop → FULL. Pop & !push → EMPTY. Push & pop → ONE, with the new entry becoming the head in the same edge.
  - FULL: pop → ONE, with the second entry promoted to head. No push is possible.
- s_ready is a registered output, high in EMPTY and ONE, low in FULL. It depends only on state, never combinationally on m_ready.
- m_valid is high in ONE and FULL. m_* outputs come straight from the head entry registers.
- Latency: a result pushed into EMPTY appears on m_* at the next cycle (1-cycle latency). Throughput is 1 result/cycle while m_ready stays high.
- m_valid, once high, holds with m_* stable until pop. The stage never drops or reorders entries.
- Accumulator: acc_q is loaded with the head m_data on every pop, visible the cycle after pop.
  - acc_q is unchanged when there is no pop.
  - Op 00 (pass B) retires and loads acc_q like any other op.
- s_valid while s_ready is low: ignored. Upstream must hold its inputs; the stage does not sample them.
- Reset (rst_n low at an edge, also mid-operation): state→EMPTY, s_ready→1, m_valid→0, m_data/m_op/m_tag/m_zero/m_parity→0, acc_q→0.
  - All buffered entries are discarded.
  - Push and pop in the same cycle as reset have no effect.
- Unused entry contents are don't-care but must not reach m_* while m_valid is 0. m_* are held at last values or 0.

Optional Feature:
- Macro: BITWISE_RESULT_STAGE_PERF_EN.
- Defined: adds output ports perf_retired (16-bit) and perf_stall (16-bit).
  - perf_retired increments on each pop.
  - perf_stall increments each cycle with s_valid & !s_ready.
  - Both saturate at 16'hFFFF and reset to 0 with rst_n.
- Not defined: ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then single push s_q=8'hA5, s_op=01, s_tag=3, m_ready=1 → next cycle m_valid=1, m_data=A5, m_zero=0, m_parity=0, m_tag=3; cycle after pop acc_q=A5, m_valid=0.
- m_ready=0, push 8'h00 then 8'h01 on consecutive cycles → state FULL, s_ready=0 on cycle 3. Head m_data=00, m_zero=1. A third push (8'hFF) while s_ready=0 is not captured. Raise m_ready → outputs 00 then 01, never FF.
- Streaming 16 results 0..15 with s_valid=1 and m_ready=1 continuously → m_data sequence 0..15 with no bubbles after the first cycle; s_ready stays 1; final acc_q=15.
- State ONE with head 8'h3C, same-cycle push 8'hC3 and pop → next cycle m_data=C3, m_parity=0, acc_q=3C, occupancy still ONE.
- FULL with entries 8'h11, 8'h22; assert rst_n=0 for one cycle → m_valid=0, s_ready=1, acc_q=0. After reset, push 8'h7F → m_data=7F, m_parity=1.
- With BITWISE_RESULT_STAGE_PERF_EN: hold m_ready=0 and s_valid=1 for 5 cycles from EMPTY → perf_stall=3, perf_retired=0. Then pop both entries → perf_retired=2.
